// File: rtl/btn_pkg.sv
// Purpose : shared definitions for the push-button conditioner (state encoding,
//           counter width helper, default timing constants for a 12 MHz clock).
// Latency : n/a (package).
// Backpr. : n/a (package).
package btn_pkg;

    // Auto-repeat state of one button channel.
    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        HOLD     = 2'd1,
        REPEAT   = 2'd2
    } rpt_state_e;

    // Defaults for 12 MHz: 1 ms tick, 20 ms debounce, 500 ms repeat delay,
    // 100 ms repeat period.
    localparam int DEF_TICK_CYCLES        = 12000;
    localparam int DEF_DEBOUNCE_TICKS     = 20;
    localparam int DEF_REPEAT_DELAY_TICKS = 500;
    localparam int DEF_REPEAT_RATE_TICKS  = 100;

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// Purpose : one button channel: 2-FF synchroniser, tick-based debounce and
//           press/release/step pulse generation (auto-repeat optional).
// Latency : 2 sync cycles + debounce window + 1 output register cycle.
// Backpr. : none; outputs are free-running levels and single-cycle pulses.
//
// Ports   : i_clk/i_reset (async, active high), i_tick (shared timing tick),
//           i_btn (raw pin), o_level (debounced, 1 = pressed), o_press,
//           o_release, o_step (registered one-cycle pulses).
// Config  : BUTTON_AUTOREPEAT_EN enables the HOLD/REPEAT step generator;
//           without it o_step mirrors o_press.
module btn_channel
    import btn_pkg::*;
#(
    parameter bit ACTIVE_LOW         = 1'b1,
`ifdef BUTTON_AUTOREPEAT_EN
    parameter int REPEAT_DELAY_TICKS = DEF_REPEAT_DELAY_TICKS,
    parameter int REPEAT_RATE_TICKS  = DEF_REPEAT_RATE_TICKS,
`endif
    parameter int DEBOUNCE_TICKS     = DEF_DEBOUNCE_TICKS
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_step
);

    localparam int DB_W = cnt_width(DEBOUNCE_TICKS);

    logic [1:0]      sync_q, sync_d;
    logic            sample;
    logic            level_q, level_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            acc_press, acc_release;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            step_q, step_d;

    // Debounce: any cycle agreeing with the accepted level restarts the
    // window, so only an uninterrupted run of DEBOUNCE_TICKS ticks counts.
    always_comb begin
        sync_d      = {sync_q[0], i_btn};
        sample      = sync_q[1] ^ ACTIVE_LOW;
        level_d     = level_q;
        db_cnt_d    = db_cnt_q;
        acc_press   = 1'b0;
        acc_release = 1'b0;
        if (sample == level_q) begin
            db_cnt_d = '0;
        end else if (i_tick) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_TICKS - 1)) begin
                level_d     = sample;
                db_cnt_d    = '0;
                acc_press   = sample;
                acc_release = ~sample;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RPT_W = cnt_width(max_int(REPEAT_DELAY_TICKS, REPEAT_RATE_TICKS));

    rpt_state_e       state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [RPT_W-1:0] rpt_last;

    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        step_d    = 1'b0;
        // HOLD waits for the initial delay, REPEAT for the repeat period.
        rpt_last  = (state_q == HOLD) ? RPT_W'(REPEAT_DELAY_TICKS - 1)
                                      : RPT_W'(REPEAT_RATE_TICKS - 1);
        case (state_q)
            RELEASED: begin
                if (acc_press) begin
                    state_d   = HOLD;
                    press_d   = 1'b1;
                    step_d    = 1'b1;
                    rpt_cnt_d = '0;
                end
            end
            HOLD, REPEAT: begin
                // Release wins over a repeat falling due in the same cycle.
                if (acc_release) begin
                    state_d   = RELEASED;
                    release_d = 1'b1;
                    rpt_cnt_d = '0;
                end else if (i_tick) begin
                    if (rpt_cnt_q == rpt_last) begin
                        state_d   = REPEAT;
                        step_d    = 1'b1;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                    end
                end
            end
            default: begin
                state_d   = RELEASED;
                rpt_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= RELEASED;
            rpt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`else
    always_comb begin
        press_d   = acc_press;
        release_d = acc_release;
        step_d    = acc_press;
    end
`endif

    // Synchroniser resets to the idle pin level so reset never looks like a press.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q    <= {2{ACTIVE_LOW}};
            level_q   <= 1'b0;
            db_cnt_q  <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            level_q   <= level_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            step_q    <= step_d;
        end
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_step    = step_q;

endmodule

// File: rtl/button_conditioner.sv
// Purpose : N-channel push-button front end: shared tick prescaler feeding
//           independent synchronise/debounce/repeat channels.
// Latency : 2 sync cycles + (DEBOUNCE_TICKS-1)*TICK_CYCLES+1..DEBOUNCE_TICKS*TICK_CYCLES + 1 cycle.
// Backpr. : none; outputs are levels and single-cycle pulses, never stalled.
//
// Ports   : i_clk, i_reset (async, active high), i_btn[N_BTN] raw pins,
//           o_level/o_press/o_release/o_step[N_BTN] per-channel outputs.
// Config  : define BUTTON_AUTOREPEAT_EN for hold-to-repeat steps; otherwise
//           o_step equals o_press and the REPEAT_* parameters are unused.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN              = 5,
    parameter int TICK_CYCLES        = DEF_TICK_CYCLES,
    parameter int DEBOUNCE_TICKS     = DEF_DEBOUNCE_TICKS,
    parameter int REPEAT_DELAY_TICKS = DEF_REPEAT_DELAY_TICKS,
    parameter int REPEAT_RATE_TICKS  = DEF_REPEAT_RATE_TICKS,
    parameter bit ACTIVE_LOW         = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_step
);

    // A zero-length tick, window or period has no meaningful behaviour.
    if (N_BTN < 1 || TICK_CYCLES < 1 || DEBOUNCE_TICKS < 1 ||
        REPEAT_DELAY_TICKS < 1 || REPEAT_RATE_TICKS < 1) begin : g_bad_params
        $error("button_conditioner: all parameters must be >= 1");
    end

    localparam int TICK_W = cnt_width(TICK_CYCLES - 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;

    // Shared prescaler: one tick cycle per TICK_CYCLES clocks, at the wrap.
    always_comb begin
        tick       = (tick_cnt_q == TICK_W'(TICK_CYCLES - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_channel #(
            .ACTIVE_LOW        (ACTIVE_LOW),
`ifdef BUTTON_AUTOREPEAT_EN
            .REPEAT_DELAY_TICKS(REPEAT_DELAY_TICKS),
            .REPEAT_RATE_TICKS (REPEAT_RATE_TICKS),
`endif
            .DEBOUNCE_TICKS    (DEBOUNCE_TICKS)
        ) u_chan (
            .i_clk    (i_clk),
            .i_reset  (i_reset),
            .i_tick   (tick),
            .i_btn    (i_btn[g]),
            .o_level  (o_level[g]),
            .o_press  (o_press[g]),
            .o_release(o_release[g]),
            .o_step   (o_step[g])
        );
    end

endmodule
